// File: rtl/mul_stage.sv
// Sequential shift-add unsigned multiplier feeding the square-root stage.
// One partial product per clock; a one-entry output register lets the next multiply overlap a stalled consumer.
module mul_stage #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     a_bi,
    input  logic [WIDTH-1:0]     b_bi,
    input  logic                 start_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic [2*WIDTH-1:0]   y_bo,
    output logic                 y_valid_o,
    input  logic                 ds_ready_i
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WORK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_sum;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]   cnt_q;
    logic            accept;
    logic            last_step;
    logic            slot_free;
    logic            load_y;
    logic [PW-1:0]   load_val;

    assign accept    = start_i && (state_q == IDLE);
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    // The slot counts as free when it is empty or being emptied on this same edge.
    assign slot_free = !y_valid_o || ds_ready_i;
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign ready_o = (state_q == IDLE);
    assign busy_o  = !ready_o;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        load_y   = 1'b0;
        load_val = acc_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = WORK;
            end
            WORK: begin
                if (last_step) begin
                    if (slot_free) begin
                        load_y   = 1'b1;
                        load_val = acc_sum;
                        state_d  = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (slot_free) begin
                    load_y  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand_q  <= PW'(a_bi);
                        mplier_q <= b_bi;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                WORK: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A load on a transfer edge overrides the clear, keeping y_valid_o high with the new product.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_bo      <= '0;
            y_valid_o <= 1'b0;
        end else if (load_y) begin
            y_bo      <= load_val;
            y_valid_o <= 1'b1;
        end else if (y_valid_o && ds_ready_i) begin
            y_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_stage.sv
// Self-checking bench for mul_stage: directed scenarios plus a randomized run against a queue-based product model.
module tb_mul_stage;

    localparam int WIDTH = 8;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic [WIDTH-1:0]   a_bi = '0;
    logic [WIDTH-1:0]   b_bi = '0;
    logic               start_i = 1'b0;
    logic               ready_o;
    logic               busy_o;
    logic [2*WIDTH-1:0] y_bo;
    logic               y_valid_o;
    logic               ds_ready_i = 1'b0;

    int total = 0;
    int bad   = 0;

    mul_stage #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .a_bi       (a_bi),
        .b_bi       (b_bi),
        .start_i    (start_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .y_bo       (y_bo),
        .y_valid_o  (y_valid_o),
        .ds_ready_i (ds_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Presents one operand pair for a single cycle; returns at the negedge after the accept edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk_i);
        a_bi    = a;
        b_bi    = b;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        a_bi    = $urandom;
        b_bi    = $urandom;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1)   begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (y_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", y_valid_o); end
        total++; if (y_bo !== 16'd0)     begin bad++; $display("FAIL reset_y: got %0d want 0", y_bo); end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        total++; if (ready_o !== 1'b1 || y_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_release: ready=%b valid=%b want 1/0", ready_o, y_valid_o);
        end
    endtask

    task automatic test_basic();
        ds_ready_i = 1'b1;
        start_op(8'd13, 8'd11);
        total++; if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL basic_busy: ready=%b busy=%b want 0/1", ready_o, busy_o);
        end
        repeat (7) tick();
        total++; if (y_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early: valid=%b after 7 work edges, want 0", y_valid_o); end
        tick();
        total++; if (y_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", y_valid_o); end
        total++; if (y_bo !== 16'd143)   begin bad++; $display("FAIL basic_y: got %0d want 143", y_bo); end
        total++; if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++; $display("FAIL basic_ready: ready=%b busy=%b want 1/0", ready_o, busy_o);
        end
        tick();
        total++; if (y_valid_o !== 1'b0) begin bad++; $display("FAIL basic_xfer: valid=%b want 0", y_valid_o); end
    endtask

    task automatic test_extremes();
        logic [WIDTH-1:0] ta [3];
        logic [WIDTH-1:0] tb [3];
        int               te [3];
        ta = '{8'd255, 8'd0,   8'd1};
        tb = '{8'd255, 8'd200, 8'd255};
        te = '{65025,  0,      255};
        ds_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i]);
            repeat (7) tick();
            total++; if (y_valid_o !== 1'b0) begin bad++; $display("FAIL ext_early[%0d]: valid=%b want 0", i, y_valid_o); end
            tick();
            total++; if (y_valid_o !== 1'b1 || y_bo !== 16'(te[i])) begin
                bad++; $display("FAIL ext_y[%0d]: valid=%b y=%0d want 1/%0d", i, y_valid_o, y_bo, te[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        ds_ready_i = 1'b0;
        start_op(8'd7, 8'd9);
        repeat (8) tick();
        total++; if (y_valid_o !== 1'b1 || y_bo !== 16'd63) begin
            bad++; $display("FAIL bp_first: valid=%b y=%0d want 1/63", y_valid_o, y_bo);
        end
        start_op(8'd20, 8'd30);
        total++; if (y_bo !== 16'd63 || y_valid_o !== 1'b1) begin
            bad++; $display("FAIL bp_hold1: valid=%b y=%0d want 1/63", y_valid_o, y_bo);
        end
        repeat (8) tick();
        total++; if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL bp_done: ready=%b busy=%b want 0/1", ready_o, busy_o);
        end
        repeat (2) tick();
        total++; if (y_bo !== 16'd63 || y_valid_o !== 1'b1 || ready_o !== 1'b0) begin
            bad++; $display("FAIL bp_hold2: valid=%b y=%0d ready=%b want 1/63/0", y_valid_o, y_bo, ready_o);
        end
        ds_ready_i = 1'b1;
        tick();
        ds_ready_i = 1'b0;
        total++; if (y_valid_o !== 1'b1 || y_bo !== 16'd600 || ready_o !== 1'b1) begin
            bad++; $display("FAIL bp_swap: valid=%b y=%0d ready=%b want 1/600/1", y_valid_o, y_bo, ready_o);
        end
        tick();
        total++; if (y_valid_o !== 1'b1 || y_bo !== 16'd600) begin
            bad++; $display("FAIL bp_hold3: valid=%b y=%0d want 1/600", y_valid_o, y_bo);
        end
        ds_ready_i = 1'b1;
        tick();
        total++; if (y_valid_o !== 1'b0) begin bad++; $display("FAIL bp_drain: valid=%b want 0", y_valid_o); end
    endtask

    task automatic test_ignored_start();
        bit extra;
        ds_ready_i = 1'b1;
        start_op(8'd5, 8'd5);
        repeat (2) tick();
        a_bi    = 8'd3;
        b_bi    = 8'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL ign_ready: got %b want 0", ready_o); end
        repeat (4) tick();
        total++; if (y_valid_o !== 1'b0) begin bad++; $display("FAIL ign_early: valid=%b want 0", y_valid_o); end
        tick();
        total++; if (y_valid_o !== 1'b1 || y_bo !== 16'd25) begin
            bad++; $display("FAIL ign_y: valid=%b y=%0d want 1/25", y_valid_o, y_bo);
        end
        extra = 1'b0;
        repeat (12) begin
            tick();
            if (y_valid_o !== 1'b0 || ready_o !== 1'b1) extra = 1'b1;
        end
        total++; if (extra) begin bad++; $display("FAIL ign_second: extra result or busy seen, got 1 want 0"); end
    endtask

    task automatic test_reset_mid_op();
        ds_ready_i = 1'b0;
        start_op(8'd2, 8'd5);
        repeat (8) tick();
        total++; if (y_valid_o !== 1'b1 || y_bo !== 16'd10) begin
            bad++; $display("FAIL rst_pre: valid=%b y=%0d want 1/10", y_valid_o, y_bo);
        end
        start_op(8'd9, 8'd9);
        repeat (4) tick();
        #1 rst_i = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || y_valid_o !== 1'b0 || y_bo !== 16'd0) begin
            bad++; $display("FAIL rst_async: ready=%b busy=%b valid=%b y=%0d want 1/0/0/0", ready_o, busy_o, y_valid_o, y_bo);
        end
        @(negedge clk_i);
        rst_i      = 1'b0;
        ds_ready_i = 1'b1;
        repeat (3) tick();
        total++; if (y_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL rst_after: valid=%b ready=%b want 0/1", y_valid_o, ready_o);
        end
        start_op(8'd2, 8'd3);
        repeat (8) tick();
        total++; if (y_valid_o !== 1'b1 || y_bo !== 16'd6) begin
            bad++; $display("FAIL rst_post: valid=%b y=%0d want 1/6", y_valid_o, y_bo);
        end
        tick();
    endtask

    // Model: every accepted pair must appear as a*b on the output, in order, exactly once.
    task automatic test_random();
        logic [15:0]      exp_q [$];
        logic [WIDTH-1:0] ra, rb;
        logic [15:0]      y_seen, y_prev, want;
        bit               acc_now, xfer_now, hold_prev;
        int               n_acc, n_xfer, cyc;
        n_acc = 0; n_xfer = 0; cyc = 0; hold_prev = 1'b0; y_prev = '0;
        @(negedge clk_i);
        while ((n_acc < 500 || exp_q.size() != 0) && cyc < 20000) begin
            if (hold_prev) begin
                total++; if (y_valid_o !== 1'b1 || y_bo !== y_prev) begin
                    bad++; $display("FAIL rnd_hold: valid=%b y=%0d want 1/%0d", y_valid_o, y_bo, y_prev);
                end
            end
            ra = $urandom; rb = $urandom;
            a_bi       = ra;
            b_bi       = rb;
            start_i    = (n_acc < 500) && ($urandom_range(0, 1) == 1);
            ds_ready_i = (n_acc >= 500) || ($urandom_range(0, 2) != 0);
            acc_now    = start_i && ready_o;
            xfer_now   = y_valid_o && ds_ready_i;
            y_seen     = y_bo;
            hold_prev  = y_valid_o && !ds_ready_i;
            y_prev     = y_bo;
            @(posedge clk_i);
            if (xfer_now) begin
                n_xfer++;
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                total++; if (y_seen !== want) begin
                    bad++; $display("FAIL rnd_y[%0d]: got %0d want %0d", n_xfer, y_seen, want);
                end
            end
            if (acc_now) begin
                exp_q.push_back(16'(ra) * 16'(rb));
                n_acc++;
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i    = 1'b0;
        ds_ready_i = 1'b1;
        tick();
        total++; if (n_acc != 500 || n_xfer != 500 || exp_q.size() != 0) begin
            bad++; $display("FAIL rnd_count: acc=%0d xfer=%0d left=%0d want 500/500/0", n_acc, n_xfer, exp_q.size());
        end
        total++; if (y_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_dup: valid=%b after drain want 0", y_valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
